// File: rtl/acs_trellis_ctrl_pkg.sv
// Shared constants for the ACS trellis sequencer: state encoding, index limits
// and a constant-width helper.
package acs_trellis_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int H_PERIOD_MIN   = 2;
  localparam int H_PERIOD_MAX   = 4;
  localparam int SUB_CYCLES_MAX = 4;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((32'sd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/acs_norm_arbiter.sv
// Bank-wide normalize broadcast: OR of all unit requests, held for one symbol,
// never asserted on two consecutive symbols.
module acs_norm_arbiter #(
  parameter int NUM_ACS = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               strobe,
  input  logic [NUM_ACS-1:0] req,
  output logic               normalize
);

  // Requests seen while a broadcast is active are dropped; units re-request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      normalize <= 1'b0;
    end else if (clear) begin
      normalize <= 1'b0;
    end else if (strobe) begin
      normalize <= (|req) & ~normalize;
    end
  end

endmodule

// File: rtl/acs_trellis_ctrl.sv
// Symbol sequencer for a multi-h ACS bank: slot select, modulation-index phase,
// start-up metric clear, normalize broadcast, traceback readiness and overrun flag.
module acs_trellis_ctrl
  import acs_trellis_ctrl_pkg::*;
#(
  parameter int NUM_ACS    = 16,
  parameter int H_PERIOD   = 2,
  parameter int SUB_CYCLES = 4,
  parameter int INIT_SYMS  = 2,
  parameter int TB_DEPTH   = 32,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                enable,
  input  logic                symEn,
  input  logic [NUM_ACS-1:0]  normalizeReq,
  input  logic                errClear,
  output logic [1:0]          muxSel,
  output logic [1:0]          hIndex,
  output logic                symEnEven,
  output logic                normalizeAll,
  output logic                clearMetrics,
  output logic                decisionValid,
  output logic                overrunErr,
  output logic [CNT_BITS-1:0] symCount,
  output logic [1:0]          state
);

  localparam int H_LEN = (H_PERIOD < H_PERIOD_MIN) ? H_PERIOD_MIN :
                         ((H_PERIOD > H_PERIOD_MAX) ? H_PERIOD_MAX : H_PERIOD);
  localparam int SUB_LEN = (SUB_CYCLES > SUB_CYCLES_MAX) ? SUB_CYCLES_MAX :
                           ((SUB_CYCLES < 1) ? 1 : SUB_CYCLES);
  localparam logic [1:0] MUX_LAST = 2'(SUB_LEN - 1);
  localparam logic [1:0] H_LAST   = 2'(H_LEN - 1);
  localparam int INIT_W = (clog2(INIT_SYMS + 1) < 1) ? 1 : clog2(INIT_SYMS + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_SYMS - 1);
  localparam logic DIRECT_RUN = (INIT_SYMS <= 1);
  localparam logic [CNT_BITS-1:0] TB_TARGET = CNT_BITS'(TB_DEPTH);

  logic [INIT_W-1:0]   init_cnt;
  logic                init_done;
  logic                sym_hit;
  logic                run_strobe;
  logic                norm_strobe;
  logic                norm_clear;
  logic                overrun_hit;
  logic [CNT_BITS-1:0] count_next;
  logic [1:0]          h_next;

  // Strobe qualification; the strobe that leaves INIT already counts as a RUN symbol.
  always_comb begin
    init_done   = (init_cnt == INIT_LAST);
    sym_hit     = enable & symEn;
    run_strobe  = sym_hit & ((state == ST_RUN) |
                             ((state == ST_INIT) & init_done) |
                             ((state == ST_IDLE) & DIRECT_RUN));
    norm_strobe = sym_hit & (state == ST_RUN);
    norm_clear  = ~(enable & (state == ST_RUN));
    overrun_hit = sym_hit & (state != ST_IDLE) & (muxSel != MUX_LAST);
    count_next  = symCount + CNT_BITS'(1'b1);
    if (hIndex == H_LAST) begin
      h_next = 2'd0;
    end else begin
      h_next = hIndex + 2'd1;
    end
  end

  // Sequencing FSM and start-up metric clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ST_IDLE;
      init_cnt     <= {INIT_W{1'b0}};
      clearMetrics <= 1'b0;
    end else if (!enable) begin
      state        <= ST_IDLE;
      init_cnt     <= {INIT_W{1'b0}};
      clearMetrics <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (symEn) begin
          state        <= DIRECT_RUN ? ST_RUN : ST_INIT;
          clearMetrics <= ~DIRECT_RUN;
          init_cnt     <= INIT_W'(1'b1);
        end
        ST_INIT: if (symEn) begin
          if (init_done) begin
            state        <= ST_RUN;
            clearMetrics <= 1'b0;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1'b1);
          end
        end
        ST_RUN: state <= ST_RUN;
        default: begin
          state        <= ST_IDLE;
          init_cnt     <= {INIT_W{1'b0}};
          clearMetrics <= 1'b0;
        end
      endcase
    end
  end

  // Rotator slot select: restarts on each strobe, saturates at the last slot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      muxSel <= MUX_LAST;
    end else if (!enable || (state == ST_IDLE)) begin
      muxSel <= MUX_LAST;
    end else if (symEn) begin
      muxSel <= 2'd0;
    end else if (muxSel != MUX_LAST) begin
      muxSel <= muxSel + 2'd1;
    end
  end

  // Multi-h index phase, only advanced by strobes taken while already in RUN.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hIndex    <= 2'd0;
      symEnEven <= 1'b1;
    end else if (!enable || (state != ST_RUN)) begin
      hIndex    <= 2'd0;
      symEnEven <= 1'b1;
    end else if (symEn) begin
      hIndex    <= h_next;
      symEnEven <= (h_next == 2'd0);
    end
  end

  // Symbol count and traceback readiness; a count wrap leaves readiness set.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      symCount      <= {CNT_BITS{1'b0}};
      decisionValid <= 1'b0;
    end else if (run_strobe) begin
      symCount <= count_next;
      if (count_next == TB_TARGET) begin
        decisionValid <= 1'b1;
      end
    end else if (!enable || (state != ST_RUN)) begin
      symCount      <= {CNT_BITS{1'b0}};
      decisionValid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new violation outranks a clear request.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overrunErr <= 1'b0;
    end else if (overrun_hit) begin
      overrunErr <= 1'b1;
    end else if (errClear) begin
      overrunErr <= 1'b0;
    end
  end

  acs_norm_arbiter #(
    .NUM_ACS(NUM_ACS)
  ) u_norm_arbiter (
    .clk      (clk),
    .reset_n  (resetN),
    .clear    (norm_clear),
    .strobe   (norm_strobe),
    .req      (normalizeReq),
    .normalize(normalizeAll)
  );

endmodule

// File: tb/tb_acs_trellis_ctrl.sv
// Directed bench for acs_trellis_ctrl; a second instance runs with H_PERIOD=3.
module tb_acs_trellis_ctrl;

  logic        clk = 1'b0;
  logic        resetN, enable, symEn, errClear;
  logic [15:0] normalizeReq;

  logic [1:0]  muxSel, hIndex, state;
  logic        symEnEven, normalizeAll, clearMetrics, decisionValid, overrunErr;
  logic [15:0] symCount;

  logic [1:0]  muxSel3, hIndex3, state3;
  logic        symEnEven3, normalizeAll3, clearMetrics3, decisionValid3, overrunErr3;
  logic [15:0] symCount3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acs_trellis_ctrl dut (
    .clk(clk), .resetN(resetN), .enable(enable), .symEn(symEn),
    .normalizeReq(normalizeReq), .errClear(errClear),
    .muxSel(muxSel), .hIndex(hIndex), .symEnEven(symEnEven),
    .normalizeAll(normalizeAll), .clearMetrics(clearMetrics),
    .decisionValid(decisionValid), .overrunErr(overrunErr),
    .symCount(symCount), .state(state)
  );

  acs_trellis_ctrl #(.H_PERIOD(3)) dut3 (
    .clk(clk), .resetN(resetN), .enable(enable), .symEn(symEn),
    .normalizeReq(normalizeReq), .errClear(errClear),
    .muxSel(muxSel3), .hIndex(hIndex3), .symEnEven(symEnEven3),
    .normalizeAll(normalizeAll3), .clearMetrics(clearMetrics3),
    .decisionValid(decisionValid3), .overrunErr(overrunErr3),
    .symCount(symCount3), .state(state3)
  );

  // One-clock strobe issued from a falling edge; returns on the next falling edge.
  task automatic pulse();
    symEn = 1'b1;
    @(negedge clk);
    symEn = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    resetN = 1'b0; enable = 1'b0; symEn = 1'b0; errClear = 1'b0; normalizeReq = 16'h0000;
    gap(2);
    total++; if ({muxSel, hIndex, symEnEven, normalizeAll, clearMetrics, decisionValid, overrunErr} !== 9'b11_00_1_0000) begin
      bad++; $display("FAIL reset_flags: got %b want 110010000", {muxSel, hIndex, symEnEven, normalizeAll, clearMetrics, decisionValid, overrunErr}); end
    total++; if (symCount !== 16'd0 || state !== 2'd0) begin
      bad++; $display("FAIL reset_count_state: got cnt=%0d st=%0d want 0 0", symCount, state); end
    resetN = 1'b1;
    gap(1);
  endtask

  task automatic test_init();
    enable = 1'b1;
    gap(1);
    pulse();
    total++; if (state !== 2'd1 || clearMetrics !== 1'b1 || muxSel !== 2'd3) begin
      bad++; $display("FAIL init_entry: got st=%0d clr=%0d mux=%0d want 1 1 3", state, clearMetrics, muxSel); end
    gap(3);
    total++; if (state !== 2'd1 || clearMetrics !== 1'b1) begin
      bad++; $display("FAIL init_hold: got st=%0d clr=%0d want 1 1", state, clearMetrics); end
    pulse();
    total++; if (state !== 2'd2 || clearMetrics !== 1'b0 || symCount !== 16'd1) begin
      bad++; $display("FAIL init_to_run: got st=%0d clr=%0d cnt=%0d want 2 0 1", state, clearMetrics, symCount); end
    total++; if (hIndex !== 2'd0 || symEnEven !== 1'b1 || hIndex3 !== 2'd0) begin
      bad++; $display("FAIL init_hindex: got h=%0d even=%0d h3=%0d want 0 1 0", hIndex, symEnEven, hIndex3); end
    for (int i = 0; i < 4; i++) begin
      total++; if (muxSel !== 2'(i)) begin
        bad++; $display("FAIL init_muxsel%0d: got %0d want %0d", i, muxSel, i); end
      if (i < 3) @(negedge clk);
    end
    total++; if (overrunErr !== 1'b0) begin
      bad++; $display("FAIL init_overrun: got %0d want 0", overrunErr); end
  endtask

  task automatic test_hindex();
    logic [1:0] exp2 [4];
    logic [1:0] exp3 [4];
    exp2 = '{2'd1, 2'd0, 2'd1, 2'd0};
    exp3 = '{2'd1, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      pulse();
      total++; if (hIndex !== exp2[i] || symEnEven !== (exp2[i] == 2'd0)) begin
        bad++; $display("FAIL hindex_h2_%0d: got h=%0d even=%0d want h=%0d", i, hIndex, symEnEven, exp2[i]); end
      total++; if (hIndex3 !== exp3[i] || symEnEven3 !== (exp3[i] == 2'd0)) begin
        bad++; $display("FAIL hindex_h3_%0d: got h=%0d even=%0d want h=%0d", i, hIndex3, symEnEven3, exp3[i]); end
      total++; if (normalizeAll !== 1'b0 || symCount !== 16'(i + 2)) begin
        bad++; $display("FAIL hindex_norm_cnt%0d: got n=%0d cnt=%0d want 0 %0d", i, normalizeAll, symCount, i + 2); end
      gap(3);
    end
  endtask

  task automatic test_normalize();
    logic expn [3];
    expn = '{1'b1, 1'b0, 1'b1};
    normalizeReq = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      pulse();
      total++; if (normalizeAll !== expn[i]) begin
        bad++; $display("FAIL norm_seq%0d: got %0d want %0d", i, normalizeAll, expn[i]); end
      gap(2);
      total++; if (normalizeAll !== expn[i]) begin
        bad++; $display("FAIL norm_hold%0d: got %0d want %0d", i, normalizeAll, expn[i]); end
      gap(1);
    end
    normalizeReq = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      pulse();
      total++; if (normalizeAll !== 1'b0) begin
        bad++; $display("FAIL norm_zero%0d: got %0d want 0", i, normalizeAll); end
      gap(3);
    end
  endtask

  task automatic test_reset_midrun();
    total++; if (symCount !== 16'd10) begin
      bad++; $display("FAIL midrun_count: got %0d want 10", symCount); end
    #2 resetN = 1'b0;
    #1;
    total++; if ({muxSel, hIndex, symEnEven, normalizeAll, clearMetrics, decisionValid, overrunErr} !== 9'b11_00_1_0000
                 || symCount !== 16'd0 || state !== 2'd0) begin
      bad++; $display("FAIL midrun_async: got mux=%0d h=%0d cnt=%0d st=%0d want 3 0 0 0", muxSel, hIndex, symCount, state); end
    @(negedge clk);
    resetN = 1'b1;
    gap(1);
    pulse();
    total++; if (state !== 2'd1 || clearMetrics !== 1'b1) begin
      bad++; $display("FAIL restart_init: got st=%0d clr=%0d want 1 1", state, clearMetrics); end
    gap(3);
    pulse();
    total++; if (state !== 2'd2 || symCount !== 16'd1 || clearMetrics !== 1'b0) begin
      bad++; $display("FAIL restart_run: got st=%0d cnt=%0d clr=%0d want 2 1 0", state, symCount, clearMetrics); end
    gap(3);
  endtask

  task automatic test_overrun();
    pulse();
    gap(1);
    pulse();
    total++; if (overrunErr !== 1'b1 || symCount !== 16'd3) begin
      bad++; $display("FAIL overrun_set: got err=%0d cnt=%0d want 1 3", overrunErr, symCount); end
    gap(3);
    total++; if (overrunErr !== 1'b1) begin
      bad++; $display("FAIL overrun_sticky: got %0d want 1", overrunErr); end
    errClear = 1'b1;
    @(negedge clk);
    errClear = 1'b0;
    total++; if (overrunErr !== 1'b0) begin
      bad++; $display("FAIL overrun_clear: got %0d want 0", overrunErr); end
    pulse();
    total++; if (overrunErr !== 1'b0 || symCount !== 16'd4) begin
      bad++; $display("FAIL overrun_legal: got err=%0d cnt=%0d want 0 4", overrunErr, symCount); end
    gap(1);
    symEn = 1'b1; errClear = 1'b1;
    @(negedge clk);
    symEn = 1'b0; errClear = 1'b0;
    total++; if (overrunErr !== 1'b1 || symCount !== 16'd5) begin
      bad++; $display("FAIL overrun_set_wins: got err=%0d cnt=%0d want 1 5", overrunErr, symCount); end
    gap(3);
    errClear = 1'b1;
    @(negedge clk);
    errClear = 1'b0;
    total++; if (overrunErr !== 1'b0) begin
      bad++; $display("FAIL overrun_clear2: got %0d want 0", overrunErr); end
  endtask

  task automatic test_decision();
    for (int i = 0; i < 26; i++) begin
      pulse();
      gap(3);
    end
    total++; if (decisionValid !== 1'b0 || symCount !== 16'd31) begin
      bad++; $display("FAIL dv_before: got dv=%0d cnt=%0d want 0 31", decisionValid, symCount); end
    pulse();
    total++; if (decisionValid !== 1'b1 || symCount !== 16'd32) begin
      bad++; $display("FAIL dv_rise: got dv=%0d cnt=%0d want 1 32", decisionValid, symCount); end
    gap(1);
    pulse();
    total++; if (decisionValid !== 1'b1 || overrunErr !== 1'b1 || symCount !== 16'd33) begin
      bad++; $display("FAIL dv_hold: got dv=%0d err=%0d cnt=%0d want 1 1 33", decisionValid, overrunErr, symCount); end
    enable = 1'b0;
    @(negedge clk);
    total++; if (state !== 2'd0 || decisionValid !== 1'b0 || symCount !== 16'd0 || clearMetrics !== 1'b0) begin
      bad++; $display("FAIL disable_idle: got st=%0d dv=%0d cnt=%0d clr=%0d want 0 0 0 0", state, decisionValid, symCount, clearMetrics); end
    total++; if (muxSel !== 2'd3 || hIndex !== 2'd0 || symEnEven !== 1'b1 || overrunErr !== 1'b1) begin
      bad++; $display("FAIL disable_outputs: got mux=%0d h=%0d even=%0d err=%0d want 3 0 1 1", muxSel, hIndex, symEnEven, overrunErr); end
    errClear = 1'b1;
    @(negedge clk);
    errClear = 1'b0;
    total++; if (overrunErr !== 1'b0) begin
      bad++; $display("FAIL idle_errclear: got %0d want 0", overrunErr); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_hindex();
    test_normalize();
    test_reset_midrun();
    test_overrun();
    test_decision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acs_trellis_ctrl.md
Name: acs_trellis_ctrl

Overview:
Sequencer for a bank of NUM_ACS multi-h add-compare-select units. It generates the shared per-symbol sub-cycle select and the multi-h modulation-index phase (symEnEven) for the whole bank. It clears accumulated metrics at start-up, collects per-unit normalization requests and broadcasts a single bank-wide normalize for one symbol. It also flags traceback readiness and symbol-timing overruns. It sits between the symbol timing/tilt logic and the ACS bank.

Parameters:
NUM_ACS, 16, number of ACS units in the bank (normalization request width)
H_PERIOD, 2, multi-h index cycle length in symbols (2..4)
SUB_CYCLES, 4, serial rotator slots per symbol (power of 2, max 4)
INIT_SYMS, 2, symbols of forced metric clear after start
TB_DEPTH, 32, RUN symbols before decisions are valid (1..255)
CNT_BITS, 16, symbol counter width

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
enable  in  1  run request; low returns the block to IDLE
symEn  in  1  one-clock symbol strobe
normalizeReq  in  NUM_ACS  per-ACS normalizeOut
errClear  in  1  clears overrunErr
muxSel  out  2  rotator/ACS input slot select
hIndex  out  2  current multi-h index, 0..H_PERIOD-1
symEnEven  out  1  high when hIndex==0
normalizeAll  out  1  broadcast normalizeIn to every ACS
clearMetrics  out  1  forces accumulated metrics to zero
decisionValid  out  1  traceback output trustworthy
overrunErr  out  1  sticky symbol-spacing error
symCount  out  CNT_BITS  symbols processed in RUN
state  out  2  debug: 0 IDLE, 1 INIT, 2 RUN

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (resetN). All outputs are registered.
- Reset values: muxSel=SUB_CYCLES-1, hIndex=0, symEnEven=1, normalizeAll=0, clearMetrics=0, decisionValid=0, overrunErr=0, symCount=0, state=IDLE.
- FSM:
  - IDLE -> INIT on the first symEn with enable=1. clearMetrics goes to 1 the cycle after that strobe.
  - INIT counts symEn strobes, including the entry strobe. On the INIT_SYMS-th strobe it moves to RUN and clearMetrics goes to 0 in the next cycle.
  - RUN stays in RUN while enable=1.
  - enable=0 in any state: return to IDLE on the next clock. All outputs take their reset values except overrunErr, which holds.
- muxSel:
  - In INIT/RUN, symEn loads 0 on the next clock.
  - Otherwise it increments each clock, saturating at SUB_CYCLES-1.
  - In IDLE it holds SUB_CYCLES-1.
- hIndex:
  - Advances modulo H_PERIOD on each symEn in RUN. The wrap from H_PERIOD-1 goes to 0.
  - Held at 0 in INIT and IDLE.
  - symEnEven is updated in the same cycle as hIndex.
- normalizeAll:
  - Updated only on symEn in RUN: normalizeAll <= (|normalizeReq) & ~normalizeAll.
  - Once set, it holds for exactly one symbol period.
  - Normalization is never issued on two consecutive symbols. Requests arriving while normalizeAll=1 are dropped; the ACS re-requests them.
  - Forced 0 in IDLE/INIT.
- symCount: increments on each symEn in RUN, including the strobe that entered RUN. Wraps at 2^CNT_BITS.
- decisionValid: set when symCount reaches TB_DEPTH in RUN. It stays set until the block leaves RUN; symCount wrap does not clear it.
- overrunErr:
  - Set when symEn arrives in INIT/RUN while muxSel != SUB_CYCLES-1, i.e. strobes fewer than SUB_CYCLES clocks apart. The offending symEn is still processed.
  - errClear clears it the next clock. A simultaneous set wins over errClear.
- Reset asserted mid-symbol: immediate return to reset values; no partial state survives.
- Latency: every symEn-driven output changes on the clock after the strobe.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, INIT=1, RUN=2);
  - the SUB_CYCLES/H_PERIOD limits;
  - a clog2 function for counter widths.
- One natural sub-module, acs_norm_arbiter: the OR-reduction plus one-symbol hold and consecutive-symbol suppression of normalizeAll.

Test Plan:
- Reset release, enable=1, symEn every 4 clocks -> clearMetrics=1 for exactly 2 symbols. RUN entered at the 2nd strobe. muxSel sequence 0,1,2,3 after each strobe; overrunErr=0.
- RUN, H_PERIOD=2 -> hIndex toggles 0,1,0,1 and symEnEven 1,0,1,0 on successive strobes. With H_PERIOD=3, hIndex runs 0,1,2,0.
- normalizeReq bit 5 high across three consecutive strobes -> normalizeAll pattern 1,0,1. A request with all bits 0 -> stays 0.
- TB_DEPTH=32 -> decisionValid rises the clock after the 32nd RUN strobe. Dropping enable -> decisionValid=0 and state=IDLE next clock.
- symEn strobes 2 clocks apart in RUN -> overrunErr=1 and sticky. errClear with no new violation -> 0. errClear coincident with a violation -> stays 1.
- resetN pulsed low mid-RUN with symCount=10 -> all outputs at reset values asynchronously; restart requires a new INIT of 2 symbols.
